dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single data-memory port between the single-cycle CPU datapath (load/store) and two secondary requesters: the Mandelbrot compute engine (read/write) and the VGA scan-out (read-only).
- The CPU normally has absolute priority. The secondaries are served round-robin in idle CPU cycles.
- An anti-starvation timer forces a secondary slot by stalling the CPU for one cycle. The datapath gates its PC update and register write with cpu_stall.
- Sits between the datapath memaddr/writedata/readmem and the data RAM. The RAM has a combinational read and a synchronous write.

Parameters:
- ADDR_W, 14, word-address width of the data RAM.
- DATA_W, 32, data word width.
- MAX_WAIT, 8, number of consecutive cycles a pending secondary request may be denied before a slot is forced. Legal range is 1..255.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- cpu_en  in  1  CPU performs lw/sw this cycle
- cpu_we  in  1  CPU store (valid with cpu_en)
- cpu_addr  in  32  CPU byte address; word index is cpu_addr[ADDR_W+1:2]
- cpu_wdata  in  DATA_W  CPU store data
- cpu_rdata  out  DATA_W  load data to datapath, combinational
- cpu_stall  out  1  CPU must hold PC and suppress register write this cycle
- eng_req  in  1  engine request
- eng_we  in  1  engine write
- eng_addr  in  ADDR_W  engine word address
- eng_wdata  in  DATA_W  engine write data
- eng_gnt  out  1  engine access performed this cycle
- eng_rvalid  out  1  registered read-data valid pulse
- eng_rdata  out  DATA_W  registered engine read data
- vga_req  in  1  VGA read request
- vga_addr  in  ADDR_W  VGA word address
- vga_gnt  out  1  VGA access performed this cycle
- vga_rvalid  out  1  registered read-data valid pulse
- vga_rdata  out  DATA_W  registered VGA read data
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM word address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM combinational read data

Behaviour:
- State machine with two states:
  - S_NORMAL: owner is the CPU if cpu_en. Otherwise the owner is a round-robin pick among eng_req and vga_req, with the rr pointer favouring the requester not granted last.
  - S_FORCE: owner is the round-robin pick among the secondaries. cpu_stall = cpu_en. Always returns to S_NORMAL next cycle.
- Wait counter (8 bit):
  - Increments in S_NORMAL when (eng_req|vga_req) and no secondary is granted.
  - Clears on any secondary grant.
  - When the counter reaches MAX_WAIT-1 while incrementing, next state is S_FORCE and the counter clears.
- S_FORCE with no secondary request (request withdrawn) grants nothing. cpu_stall is still asserted if cpu_en. Returns to S_NORMAL.
- Grant is a single-cycle pulse in the access cycle. The requester holds req/addr/we/wdata stable until it sees gnt. Keeping req high after gnt requests a new access.
- The rr pointer updates only on a secondary grant: it points to the other requester. With both requesting continuously, grants alternate eng, vga, eng, ...
- Mux: mem_addr/mem_we/mem_wdata come from the owner. With no owner, mem_we=0 and mem_addr=0.
- cpu_rdata = mem_rdata always. The CPU ignores it while stalled.
- Secondary read: eng_rvalid/vga_rvalid go high exactly 1 cycle after a read grant, with rdata registered from mem_rdata. An engine write grant produces no rvalid. rdata holds its value until the next read.
- A CPU store while stalled is not written. mem_we comes only from the owner.
- Reset values:
  - state S_NORMAL, counter 0, rr pointer to eng.
  - eng_rvalid=vga_rvalid=0, eng_rdata=vga_rdata=0.
  - The combinational outputs follow from these values.
- Reset asserted mid-operation discards any pending rvalid. No grant is issued while reset is high.
- cpu_en with no secondary request: no stall, no counter change.

Decomposition:
- Shared package holds:
  - owner encoding constants OWN_NONE/OWN_CPU/OWN_ENG/OWN_VGA (2 bit);
  - state constants S_NORMAL/S_FORCE.
- One natural sub-module, rr_pick2: a 2-way round-robin picker with a pointer register and update-on-grant.
- Everything else is flat.

Test Plan:
1. Reset, then cpu_en=1, cpu_we=1, cpu_addr=0x10, cpu_wdata=0xDEADBEEF -> mem_we=1, mem_addr=4, no stall. Next cycle cpu_en=1, cpu_we=0, same address -> cpu_rdata=0xDEADBEEF.
2. CPU idle; eng_req read addr 4 and vga_req addr 5 held high; RAM[4]=0xA, RAM[5]=0xB -> gnt alternates eng, vga, eng. Each rvalid follows its gnt 1 cycle later with rdata 0xA and 0xB respectively.
3. cpu_en=1 continuously, vga_req=1, MAX_WAIT=8 -> vga_gnt=0 for 8 cycles, then in cycle 9 cpu_stall=1 and vga_gnt=1. Counter cleared; pattern repeats every 9 cycles.
4. Forced cycle with cpu_we=1 to addr 0x20 and eng write addr 3 = 0x55 -> RAM[3]=0x55 and RAM[8] unchanged. After the CPU reissues next cycle, RAM[8] is written.
5. vga read granted, reset asserted the following cycle -> vga_rvalid=0, all counters/pointer at reset values, no gnt during reset.
6. Pending secondary request dropped in the cycle before S_FORCE -> S_FORCE grants nothing, cpu_stall=cpu_en for that one cycle, back to S_NORMAL.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
//   OWN_*    : encoding of which requester drives the RAM port this cycle
//   state_t  : arbiter FSM states (normal CPU-priority / forced secondary slot)
package dmem_arbiter_pkg;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_ENG  = 2'd2;
  localparam logic [1:0] OWN_VGA  = 2'd3;

  typedef enum logic {
    S_NORMAL = 1'b0,
    S_FORCE  = 1'b1
  } state_t;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin picker.
//   clk, reset : clock and synchronous active-high reset
//   en         : a grant may be issued this cycle
//   req0/req1  : requests (req0 = engine, req1 = VGA)
//   gnt0/gnt1  : one-hot grant, combinational from req/en/pointer
// The pointer names the requester that wins a tie. It moves to the other
// requester only when a grant is actually issued, so continuous requests
// from both sides alternate 0, 1, 0, ...
module rr_pick2 (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  logic ptr; // 0: req0 wins a tie, 1: req1 wins a tie

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (en) begin
      if (req0 && (!req1 || !ptr)) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (gnt0) begin
      ptr <= 1'b1;
    end else if (gnt1) begin
      ptr <= 1'b0;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one RAM port between the single-cycle CPU
// (absolute priority) and two secondaries, the Mandelbrot engine (r/w) and
// the VGA scan-out (read-only), served round-robin in idle CPU cycles.
// An anti-starvation counter forces one secondary slot by stalling the CPU.
//
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   cpu_en/cpu_we/cpu_addr/cpu_wdata   CPU load/store (byte address)
//   cpu_rdata                          = mem_rdata (combinational)
//   cpu_stall                          CPU holds PC / suppresses writeback
//   eng_req/eng_we/eng_addr/eng_wdata  engine request, word address
//   eng_gnt, eng_rvalid, eng_rdata     engine grant pulse, registered read
//   vga_req/vga_addr                   VGA read request, word address
//   vga_gnt, vga_rvalid, vga_rdata     VGA grant pulse, registered read
//   mem_we/mem_addr/mem_wdata          RAM write enable / word address / data
//   mem_rdata                          RAM combinational read data
//
// Handshake: a secondary raises req with stable addr/we/wdata and holds them
// until gnt; gnt is a one-cycle pulse in the cycle the RAM access happens.
// Holding req high after gnt asks for another access. Read data arrives one
// cycle after the grant with a one-cycle rvalid pulse; rdata then holds.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_en,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              eng_req,
  input  logic              eng_we,
  input  logic [ADDR_W-1:0] eng_addr,
  input  logic [DATA_W-1:0] eng_wdata,
  output logic              eng_gnt,
  output logic              eng_rvalid,
  output logic [DATA_W-1:0] eng_rdata,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      state, state_nxt;
  logic [7:0]  wait_cnt, wait_cnt_nxt;
  logic [1:0]  owner;
  logic        sec_en;
  logic        sec_gnt;
  logic        sec_pending;

  // Only the word-index bits of the CPU byte address reach the RAM.
  logic unused_cpu_addr_bits;
  assign unused_cpu_addr_bits = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0]};

  // Secondaries may use the port in a forced slot or whenever the CPU is
  // idle; never while reset is held.
  assign sec_en      = !reset && ((state == S_FORCE) || !cpu_en);
  assign sec_gnt     = eng_gnt | vga_gnt;
  assign sec_pending = eng_req | vga_req;

  rr_pick2 u_rr (
    .clk   (clk),
    .reset (reset),
    .en    (sec_en),
    .req0  (eng_req),
    .req1  (vga_req),
    .gnt0  (eng_gnt),
    .gnt1  (vga_gnt)
  );

  // In S_FORCE the CPU is never the owner, so a stalled store is dropped.
  always_comb begin
    owner = OWN_NONE;
    if (eng_gnt) begin
      owner = OWN_ENG;
    end else if (vga_gnt) begin
      owner = OWN_VGA;
    end else if ((state == S_NORMAL) && cpu_en) begin
      owner = OWN_CPU;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (owner)
      OWN_CPU: begin
        mem_we    = cpu_we;
        mem_addr  = cpu_addr[ADDR_W+1:2];
        mem_wdata = cpu_wdata;
      end
      OWN_ENG: begin
        mem_we    = eng_we;
        mem_addr  = eng_addr;
        mem_wdata = eng_wdata;
      end
      OWN_VGA: begin
        mem_addr  = vga_addr;
      end
      default: begin
        mem_we    = 1'b0;
      end
    endcase
  end

  assign cpu_rdata = mem_rdata;
  assign cpu_stall = (state == S_FORCE) && cpu_en;

  // Next state / wait counter. S_FORCE lasts exactly one cycle. The counter
  // already sitting at MAX_WAIT-1 when another denial happens means the
  // request has now been denied MAX_WAIT cycles, so the next slot is forced.
  always_comb begin
    state_nxt    = S_NORMAL;
    wait_cnt_nxt = wait_cnt;
    if (sec_gnt) begin
      wait_cnt_nxt = 8'd0;
    end else if ((state == S_NORMAL) && sec_pending) begin
      if (wait_cnt == WAIT_LAST) begin
        state_nxt    = S_FORCE;
        wait_cnt_nxt = 8'd0;
      end else begin
        wait_cnt_nxt = wait_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_NORMAL;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Registered read return for the secondaries.
  always_ff @(posedge clk) begin
    if (reset) begin
      eng_rvalid <= 1'b0;
      eng_rdata  <= '0;
      vga_rvalid <= 1'b0;
      vga_rdata  <= '0;
    end else begin
      eng_rvalid <= eng_gnt && !eng_we;
      vga_rvalid <= vga_gnt;
      if (eng_gnt && !eng_we) begin
        eng_rdata <= mem_rdata;
      end
      if (vga_gnt) begin
        vga_rdata <= mem_rdata;
      end
    end
  end

endmodule
